// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb
// Two-port writeback arbiter feeding a single registered register-file
// write port, plus a per-register busy scoreboard for issue hazard checks.
//
// Build option: define REGFILE_WB_RR_EN for round-robin arbitration between
// the two writeback requesters; otherwise requester 1 (LSU) always wins.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wb0_* / wb1_*             writeback request (valid/addr/data) and ready;
//                             0 = ALU, 1 = LSU
//   we, waddr, wdata          registered register-file write port
//   issue_valid, issue_rd     issued instruction and its destination
//   issue_ok                  issue_rd is not busy
//   rs1, rs2 / busy1, busy2   combinational scoreboard lookups
//   flush                     clear all busy bits at the next edge
//   sb_err                    sticky scoreboard error flag
module regfile_wb_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ok,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              busy1,
    output logic              busy2,
    input  logic              flush,
    output logic              sb_err
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              gnt0, gnt1;
    logic              acc_valid;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              err_next;

`ifdef REGFILE_WB_RR_EN
    // Requester granted at the most recent acceptance; reset to 1 so that
    // requester 0 wins the first contended cycle.
    logic last_gnt;
`endif

    // Scoreboard lookups read register state only; no bypass of same-cycle
    // issue or writeback.
    assign busy1    = busy[rs1];
    assign busy2    = busy[rs2];
    assign issue_ok = ~busy[issue_rd];

    // Arbitration: an uncontended request is always granted, so a lone
    // requester never sees an idle cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (wb0_valid && wb1_valid) begin
`ifdef REGFILE_WB_RR_EN
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
`else
                gnt1 = 1'b1;
`endif
            end else begin
                gnt0 = wb0_valid;
                gnt1 = wb1_valid;
            end
        end
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign acc_valid = gnt0 | gnt1;
    assign acc_addr  = gnt1 ? wb1_addr : wb0_addr;
    assign acc_data  = gnt1 ? wb1_data : wb0_data;
    // Writes to register 0 are consumed but never reach the register file.
    assign acc_wr    = acc_valid && (acc_addr != '0);

    // Next scoreboard state: flush (or writeback clear) first, then issue set,
    // so a same-edge set always wins.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else if (acc_wr) begin
            busy_next[acc_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Errors: issuing onto a busy destination (WAW), or a writeback to a
    // register nothing is waiting on.
    assign err_next = sb_err
                    | (issue_valid & busy[issue_rd])
                    | (acc_wr & ~busy[acc_addr]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the busy vector is reset as a whole; it is control state, not a data array, so it must start clean.
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            busy   <= '0;
            sb_err <= 1'b0;
`ifdef REGFILE_WB_RR_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            we     <= acc_wr;
            if (acc_valid) begin
                waddr <= acc_addr;
                wdata <= acc_data;
            end
            busy   <= busy_next;
            sb_err <= err_next;
`ifdef REGFILE_WB_RR_EN
            if (acc_valid) begin
                last_gnt <= gnt1;
            end
`endif
        end
    end

endmodule
